// File: rtl/tgate_arb_pkg.sv
// Shared types and helpers for the transmission-gate bus arbiter.
//   arb_state_e : arbiter FSM states
//   cnt_w/idx_w : counter and index width helpers
//   onehot      : one-hot decode of an index into a MAX_REQ-wide vector
package tgate_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } arb_state_e;

   localparam int unsigned MAX_REQ = 32;

   // Width of a counter that must hold 0..max_val, never narrower than 1 bit.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Width of an index into n requesters, never narrower than 1 bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // One-hot decode; bits at or above n stay zero.
   function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx, input int unsigned n);
      logic [MAX_REQ-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         if (i < n && i == idx) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/tgate_bus_arbiter_rr_picker.sv
// Round-robin selector: first asserted req at or above ptr, wrapping.
//   req : per-requester request
//   ptr : round-robin start position
//   any : some request is asserted
//   idx : selected requester (0 when any=0)
module rr_picker
   import tgate_arb_pkg::*;
#(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned IDX_W = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   localparam int unsigned DW = 2 * N_REQ;

   logic [DW-1:0] dbl;
   logic [DW-1:0] masked;

   // Doubling the vector turns the wrap into a straight upward search;
   // the upper copy guarantees a hit whenever any request is set.
   always_comb begin
      dbl    = {req, req};
      masked = '0;
      for (int unsigned j = 0; j < DW; j++) begin
         masked[j] = dbl[j] && (j >= 32'(ptr));
      end
      any = |req;
      idx = '0;
      // Scan downward so the lowest masked hit is the one that sticks.
      for (int unsigned j = DW; j > 0; j--) begin
         if (masked[j-1]) idx = IDX_W'((j - 1) % N_REQ);
      end
   end

endmodule

// File: rtl/tgate_bus_arbiter.sv
// Break-before-make round-robin arbiter for a wire shared through
// one-way transmission gates.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-requester request, held while the wire is wanted
//   gate_en     : one-hot-or-zero gate controls
//   owner_valid : some gate is enabled
//   owner_id    : current owner index (0 when none)
//   bus_float   : no gate enabled (IDLE or GAP)
module tgate_bus_arbiter
   import tgate_arb_pkg::*;
#(
   parameter  int unsigned N_REQ      = 4,
   parameter  int unsigned GAP_CYCLES = 1,
   parameter  int unsigned MAX_HOLD   = 0,
   localparam int unsigned IDX_W      = idx_w(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gate_en,
   output logic             owner_valid,
   output logic [IDX_W-1:0] owner_id,
   output logic             bus_float
);

   localparam int unsigned GAP_W  = cnt_w(GAP_CYCLES);
   localparam int unsigned HOLD_W = cnt_w(MAX_HOLD);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 32'd0 : MAX_HOLD - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
   localparam bit                PREEMPT_EN = (MAX_HOLD != 0);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [N_REQ-1:0]  gate_en_q, gate_en_d;
   logic              owner_valid_q, owner_valid_d;
   logic [IDX_W-1:0]  owner_id_q, owner_id_d;
   logic              bus_float_q, bus_float_d;

   logic              pick_any;
   logic [IDX_W-1:0]  pick_idx;
   logic              grant;
   logic              drop;
   logic              others_req;

   rr_picker #(.N_REQ(N_REQ)) u_pick (
      .req (req),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      gap_cnt_d     = gap_cnt_q;
      hold_cnt_d    = hold_cnt_q;
      gate_en_d     = gate_en_q;
      owner_valid_d = owner_valid_q;
      owner_id_d    = owner_id_q;
      bus_float_d   = bus_float_q;
      grant         = 1'b0;
      drop          = 1'b0;
      others_req    = |(req & ~gate_en_q);

      case (state_q)
         IDLE: begin
            if (pick_any) grant = 1'b1;
         end
         DRIVE: begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (!req[owner_id_q]) begin
               drop = 1'b1;
            end else if (PREEMPT_EN && hold_cnt_q == HOLD_LAST) begin
               // Hold budget spent: yield only if someone else is waiting.
               if (others_req) drop = 1'b1;
               else            hold_cnt_d = '0;
            end
         end
         GAP: begin
            gap_cnt_d = gap_cnt_q + 1'b1;
            if (gap_cnt_q == GAP_LAST) begin
               if (pick_any) grant = 1'b1;
               else          state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant) begin
         state_d       = DRIVE;
         gate_en_d     = N_REQ'(onehot(32'(pick_idx), N_REQ));
         owner_valid_d = 1'b1;
         owner_id_d    = pick_idx;
         bus_float_d   = 1'b0;
         hold_cnt_d    = '0;
      end

      // Release and preemption share one path: gates off, pointer past owner.
      if (drop) begin
         state_d       = GAP;
         gate_en_d     = '0;
         owner_valid_d = 1'b0;
         owner_id_d    = '0;
         bus_float_d   = 1'b1;
         gap_cnt_d     = '0;
         rr_ptr_d      = (owner_id_q == LAST_IDX) ? '0 : owner_id_q + 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         gap_cnt_q     <= '0;
         hold_cnt_q    <= '0;
         gate_en_q     <= '0;
         owner_valid_q <= 1'b0;
         owner_id_q    <= '0;
         bus_float_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         gap_cnt_q     <= gap_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         gate_en_q     <= gate_en_d;
         owner_valid_q <= owner_valid_d;
         owner_id_q    <= owner_id_d;
         bus_float_q   <= bus_float_d;
      end
   end

   assign gate_en     = gate_en_q;
   assign owner_valid = owner_valid_q;
   assign owner_id    = owner_id_q;
   assign bus_float   = bus_float_q;

   // Never more than one gate on.
   a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gate_en_q));

endmodule

// File: tb/tb_tgate_bus_arbiter.sv
// Bench for tgate_bus_arbiter: four instances with different gap/hold
// settings share one req stimulus; each is compared every cycle with a
// behavioural model, plus break-before-make, gap-length and latency checks.
module tb_tgate_bus_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned NI = 4;
   localparam int unsigned G_P  [NI] = '{1, 2, 1, 3};
   localparam int unsigned MH_P [NI] = '{0, 0, 4, 2};

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] ge  [NI];
   logic       ov  [NI];
   logic [1:0] oid [NI];
   logic       bf  [NI];

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state per instance.
   int m_owner [NI];
   int m_gap   [NI];
   int m_held  [NI];
   int m_ptr   [NI];

   // Property tracking from DUT outputs.
   logic [3:0] prev_ge [NI];
   int         zrun    [NI];
   bit         seen    [NI];
   int         waitc   [NI][N];
   int         maxw    [NI];

   tgate_bus_arbiter #(.N_REQ(4), .GAP_CYCLES(1), .MAX_HOLD(0)) u_a (
      .clk(clk), .rst_n(rst_n), .req(req), .gate_en(ge[0]),
      .owner_valid(ov[0]), .owner_id(oid[0]), .bus_float(bf[0]));
   tgate_bus_arbiter #(.N_REQ(4), .GAP_CYCLES(2), .MAX_HOLD(0)) u_b (
      .clk(clk), .rst_n(rst_n), .req(req), .gate_en(ge[1]),
      .owner_valid(ov[1]), .owner_id(oid[1]), .bus_float(bf[1]));
   tgate_bus_arbiter #(.N_REQ(4), .GAP_CYCLES(1), .MAX_HOLD(4)) u_c (
      .clk(clk), .rst_n(rst_n), .req(req), .gate_en(ge[2]),
      .owner_valid(ov[2]), .owner_id(oid[2]), .bus_float(bf[2]));
   tgate_bus_arbiter #(.N_REQ(4), .GAP_CYCLES(3), .MAX_HOLD(2)) u_d (
      .clk(clk), .rst_n(rst_n), .req(req), .gate_en(ge[3]),
      .owner_valid(ov[3]), .owner_id(oid[3]), .bus_float(bf[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input int k);
      for (int o = 0; o < int'(N); o++) begin
         int j;
         j = (m_ptr[k] + o) % int'(N);
         if (req[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset(input int k);
      m_owner[k] = -1;
      m_gap[k]   = 0;
      m_held[k]  = 0;
      m_ptr[k]   = 0;
   endtask

   task automatic trk_reset(input int k);
      prev_ge[k] = '0;
      zrun[k]    = 0;
      seen[k]    = 1'b0;
      for (int i = 0; i < int'(N); i++) waitc[k][i] = 0;
   endtask

   // One rising edge of the specification's rules.
   task automatic model_step(input int k);
      int o;
      int p;
      bit others;
      bit expired;
      if (!rst_n) begin
         model_reset(k);
      end else if (m_owner[k] >= 0) begin
         o = m_owner[k];
         others  = (req & ~(4'b0001 << o)) != 4'b0000;
         m_held[k]++;
         expired = (MH_P[k] != 0) && (m_held[k] == int'(MH_P[k]));
         if (!req[o] || (expired && others)) begin
            m_ptr[k]   = (o + 1) % int'(N);
            m_owner[k] = -1;
            m_gap[k]   = int'(G_P[k]);
         end else if (expired) begin
            m_held[k] = 0;
         end
      end else if (m_gap[k] > 0) begin
         m_gap[k]--;
         p = pick(k);
         if (m_gap[k] == 0 && p >= 0) begin
            m_owner[k] = p;
            m_held[k]  = 0;
         end
      end else begin
         p = pick(k);
         if (p >= 0) begin
            m_owner[k] = p;
            m_held[k]  = 0;
         end
      end
   endtask

   task automatic check_inst(input int k);
      logic [3:0] eg;
      bit         own;
      own = (m_owner[k] >= 0);
      eg  = own ? (4'b0001 << m_owner[k]) : 4'b0000;
      chk($sformatf("gate_en[%0d]", k), 32'(ge[k]), 32'(eg));
      chk($sformatf("owner_valid[%0d]", k), 32'(ov[k]), 32'(own));
      chk($sformatf("owner_id[%0d]", k), 32'(oid[k]), own ? 32'(m_owner[k]) : 32'd0);
      chk($sformatf("bus_float[%0d]", k), 32'(bf[k]), 32'(!own));
      chk($sformatf("onehot0[%0d]", k), 32'($onehot0(ge[k])), 32'd1);
      if (!rst_n) begin
         trk_reset(k);
      end else begin
         if (ge[k] != 4'b0000) begin
            if (prev_ge[k] != 4'b0000)
               chk($sformatf("bbm[%0d]", k), 32'(ge[k]), 32'(prev_ge[k]));
            else if (seen[k])
               chk($sformatf("gap_len[%0d]", k), 32'(zrun[k] >= int'(G_P[k])), 32'd1);
            seen[k] = 1'b1;
            zrun[k] = 0;
         end else begin
            zrun[k]++;
         end
         prev_ge[k] = ge[k];
         for (int i = 0; i < int'(N); i++) begin
            if (req[i] && !ge[k][i]) waitc[k][i]++;
            else                     waitc[k][i] = 0;
            if (waitc[k][i] > maxw[k]) maxw[k] = waitc[k][i];
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      for (int k = 0; k < int'(NI); k++) model_step(k);
      @(negedge clk);
      for (int k = 0; k < int'(NI); k++) check_inst(k);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b1111;
      for (int k = 0; k < int'(NI); k++) begin
         model_reset(k);
         trk_reset(k);
         maxw[k] = 0;
      end

      // Reset holds everything off even with all requests up.
      repeat (3) cyc();
      chk("rst_gate_en", 32'(ge[0]), 32'h0);
      chk("rst_bus_float", 32'(bf[0]), 32'h1);
      rst_n = 1'b1;
      cyc();
      chk("first_grant", 32'(ge[0]), 32'h1);
      chk("first_owner", 32'(oid[0]), 32'h0);

      // Hand-off with a two-cycle gap.
      do_reset(1);
      req = 4'b0011;
      cyc();
      cyc();
      req = 4'b0010;
      cyc(); chk("handoff_gap0", 32'(ge[1]), 32'h0);
      cyc(); chk("handoff_gap1", 32'(ge[1]), 32'h0);
      cyc(); chk("handoff_new", 32'(ge[1]), 32'h2);

      // Round-robin wrap from the last requester back to 0.
      do_reset(1);
      req = 4'b1000;
      cyc();
      req = 4'b1001;
      cyc(); chk("wrap_owner3", 32'(ge[0]), 32'h8);
      req = 4'b0001;
      cyc(); chk("wrap_gap", 32'(ge[0]), 32'h0);
      cyc(); chk("wrap_next", 32'(ge[0]), 32'h1);

      // Preemption after MAX_HOLD=4 cycles.
      do_reset(1);
      req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         cyc(); chk($sformatf("preempt_hold%0d", i), 32'(ge[2]), 32'h1);
      end
      cyc(); chk("preempt_gap", 32'(ge[2]), 32'h0);
      cyc(); chk("preempt_next", 32'(ge[2]), 32'h4);
      do_reset(1);
      req = 4'b0001;
      repeat (20) cyc();
      chk("solo_hold", 32'(ge[2]), 32'h1);

      // Asynchronous reset in the middle of a drive cycle.
      do_reset(1);
      req = 4'b0100;
      repeat (3) cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_a", 32'(ge[0]), 32'h0);
      chk("async_rst_d", 32'(ge[3]), 32'h0);
      for (int k = 0; k < int'(NI); k++) begin
         model_reset(k);
         trk_reset(k);
      end
      #1 rst_n = 1'b1;
      cyc();
      chk("post_rst_a", 32'(ge[0]), 32'h4);
      chk("post_rst_d", 32'(ge[3]), 32'h4);

      // Random traffic: requests rise at random and mostly stay until dropped.
      for (int c = 0; c < 8000; c++) begin
         for (int i = 0; i < int'(N); i++) begin
            if (req[i]) begin
               if ($urandom_range(11, 0) == 0) req[i] = 1'b0;
            end else if ($urandom_range(3, 0) == 0) begin
               req[i] = 1'b1;
            end
         end
         if (c % 1999 == 1998) do_reset(1);
         else                  cyc();
      end

      for (int k = 0; k < int'(NI); k++) begin
         if (MH_P[k] != 0)
            chk($sformatf("latency[%0d]", k),
                32'(maxw[k] <= int'(N * (MH_P[k] + G_P[k]))), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
